// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, default width and
// sequencer state encoding.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        RESP  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// Local register file for the ALU sequencer: two combinational read ports,
// one synchronous write port, synchronous clear, register 0 hardwired to zero.
module alu_seq_regfile
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = 8,
    parameter int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RW-1:0]   raddr_a,
    input  logic [RW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b,
    input  logic            wen,
    input  logic [RW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads of r0 are forced to zero independently of the storage contents.
    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the registered ALU: accepts one command, drives the ALU,
// waits out its latency, writes back and returns a response.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = 8,
    parameter int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [3:0]      cmd_op,
    input  logic [RW-1:0]   cmd_rd,
    input  logic [RW-1:0]   cmd_rs1,
    input  logic [RW-1:0]   cmd_rs2,
    input  logic            cmd_use_imm,
    input  logic [XLEN-1:0] cmd_imm,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_opcode,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [RW-1:0]   resp_rd,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_zero,
    output logic            busy
);

    seq_state_t      state;
    logic [RW-1:0]   rd_q;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rf_wen;

    alu_seq_regfile #(
        .XLEN (XLEN),
        .NREG (NREG),
        .RW   (RW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (cmd_rs1),
        .raddr_b (cmd_rs2),
        .rdata_a (rs1_data),
        .rdata_b (rs2_data),
        .wen     (rf_wen),
        .waddr   (rd_q),
        .wdata   (alu_result)
    );

    assign rf_wen     = (state == WB);
    assign cmd_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    // Only one command is ever in flight, so operands can be read straight
    // from the register file at accept without any hazard checks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rd_q       <= '0;
            resp_rd    <= '0;
            resp_data  <= '0;
            resp_zero  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a      <= rs1_data;
                        alu_b      <= cmd_use_imm ? cmd_imm : rs2_data;
                        alu_opcode <= cmd_op;
                        rd_q       <= cmd_rd;
                        state      <= ISSUE;
                    end
                end
                ISSUE: state <= EXEC;
                EXEC:  state <= WB;
                WB: begin
                    // ALU result and its zero flag both belong to this command here.
                    resp_rd   <= rd_q;
                    resp_data <= alu_result;
                    resp_zero <= alu_zero;
                    state     <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural registered ALU and
// a register-file reference model; directed cases followed by random traffic.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 8;
    localparam int RW   = 3;

    typedef struct {
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            zero;
    } respT;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [3:0]      cmd_op;
    logic [RW-1:0]   cmd_rd;
    logic [RW-1:0]   cmd_rs1;
    logic [RW-1:0]   cmd_rs2;
    logic            cmd_use_imm;
    logic [XLEN-1:0] cmd_imm;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_opcode;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            resp_valid;
    logic            resp_ready;
    logic [RW-1:0]   resp_rd;
    logic [XLEN-1:0] resp_data;
    logic            resp_zero;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int negCount = 0;
    int acceptNeg = 0;
    int bpMode = 0;
    bit outstanding = 1'b0;
    bit checking = 1'b0;
    bit readyAtNeg = 1'b0;
    bit prevStall = 1'b0;
    logic [RW-1:0]   prevRd;
    logic [XLEN-1:0] prevData;
    logic            prevZero;
    logic [XLEN-1:0] modelRf [NREG];
    respT sb[$];

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .XLEN (XLEN),
        .NREG (NREG),
        .RW   (RW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rs1     (cmd_rs1),
        .cmd_rs2     (cmd_rs2),
        .cmd_use_imm (cmd_use_imm),
        .cmd_imm     (cmd_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rd     (resp_rd),
        .resp_data   (resp_data),
        .resp_zero   (resp_zero),
        .busy        (busy)
    );

    function automatic logic [XLEN-1:0] refAlu(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            default: return '0;
        endcase
    endfunction

    // Registered ALU: result one cycle after inputs, zero flag one cycle later.
    always @(posedge clk) begin
        if (rst) begin
            alu_result <= '0;
            alu_zero   <= 1'b1;
        end else begin
            alu_result <= refAlu(alu_opcode, alu_a, alu_b);
            alu_zero   <= (alu_result == '0);
        end
    end

    always @(posedge clk) begin
        #1;
        case (bpMode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = ($urandom_range(0, 3) != 0);
            default: resp_ready = 1'b0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                               input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Monitor: handshake-level expectations every cycle, scoreboard pop on response.
    always @(negedge clk) begin
        respT e;
        negCount++;
        readyAtNeg = cmd_ready;
        if (checking) begin
            checkBit("cmd_ready", cmd_ready, !outstanding);
            checkBit("busy", busy, outstanding);
            checkBit("resp_valid", resp_valid, outstanding && (negCount >= acceptNeg + 4));
            if (prevStall && resp_valid) begin
                checkOutput("stall_rd", 32'(resp_rd), 32'(prevRd));
                checkOutput("stall_data", resp_data, prevData);
                checkBit("stall_zero", resp_zero, prevZero);
            end
            if (resp_valid && resp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_resp actual=rd%0d/%h required=none", resp_rd, resp_data);
                end else begin
                    e = sb.pop_front();
                    checkOutput("resp_rd", 32'(resp_rd), 32'(e.rd));
                    checkOutput("resp_data", resp_data, e.data);
                    checkBit("resp_zero", resp_zero, e.zero);
                    if (e.rd != '0) modelRf[e.rd] = e.data;
                end
                outstanding = 1'b0;
            end
            prevStall = resp_valid && !resp_ready;
            prevRd    = resp_rd;
            prevData  = resp_data;
            prevZero  = resp_zero;
        end
    end

    // Called at posedge+2; returns at posedge+2 after the accept edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [RW-1:0] rd,
                                 input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                                 input logic useImm, input logic [XLEN-1:0] imm);
        int waited = 0;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        respT e;
        cmd_op = op;
        cmd_rd = rd;
        cmd_rs1 = rs1;
        cmd_rs2 = rs2;
        cmd_use_imm = useImm;
        cmd_imm = imm;
        cmd_valid = 1'b1;
        forever begin
            @(posedge clk);
            if (readyAtNeg) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout actual=no_accept required=accept");
                #2;
                cmd_valid = 1'b0;
                return;
            end
        end
        a = (rs1 == '0) ? '0 : modelRf[rs1];
        b = useImm ? imm : ((rs2 == '0) ? '0 : modelRf[rs2]);
        e.rd = rd;
        e.data = refAlu(op, a, b);
        e.zero = (e.data == '0);
        sb.push_back(e);
        outstanding = 1'b1;
        acceptNeg = negCount;
        #2;
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int w = 0;
        while (outstanding && w < 300) begin
            @(posedge clk);
            w++;
        end
        #2;
        if (outstanding) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        sb.delete();
        outstanding = 1'b0;
        prevStall = 1'b0;
        for (int i = 0; i < NREG; i++) modelRf[i] = '0;
        #2;
        rst = 1'b0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_alu_a", alu_a, '0);
        checkOutput("rst_alu_b", alu_b, '0);
        checkOutput("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        checkOutput("rst_resp_rd", 32'(resp_rd), 32'd0);
        checkOutput("rst_resp_data", resp_data, '0);
        checkBit("rst_resp_zero", resp_zero, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_rd = '0;
        cmd_rs1 = '0;
        cmd_rs2 = '0;
        cmd_use_imm = 1'b0;
        cmd_imm = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        doReset();
        checking = 1'b1;
        checkResetState();

        applyStimulus(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5);
        applyStimulus(OP_SUB, 3'd2, 3'd1, 3'd0, 1'b1, 32'd5);
        applyStimulus(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFF);
        applyStimulus(OP_ADD, 3'd3, 3'd1, 3'd1, 1'b0, 32'd0);
        applyStimulus(OP_SLL, 3'd4, 3'd3, 3'd0, 1'b1, 32'd36);
        waitIdle();

        // Backpressure with a second command held on the input the whole time.
        bpMode = 2;
        fork
            begin
                int w = 0;
                while (!resp_valid && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                repeat (6) @(negedge clk);
                bpMode = 0;
            end
        join_none
        applyStimulus(OP_OR, 3'd6, 3'd4, 3'd0, 1'b1, 32'd1);
        applyStimulus(OP_AND, 3'd7, 3'd6, 3'd3, 1'b0, 32'd0);
        waitIdle();

        applyStimulus(OP_XOR, 3'd0, 3'd0, 3'd0, 1'b1, 32'hA5);
        applyStimulus(OP_OR, 3'd5, 3'd0, 3'd0, 1'b1, 32'd0);
        applyStimulus(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd7);
        applyStimulus(4'd9, 3'd1, 3'd1, 3'd0, 1'b1, 32'd3);
        applyStimulus(OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 32'd0);
        waitIdle();

        // Reset lands on the EXEC-cycle edge; the command must vanish.
        applyStimulus(OP_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 32'h55);
        @(posedge clk);
        #2;
        doReset();
        checkResetState();
        for (int k = 1; k < NREG; k++) begin
            applyStimulus(OP_ADD, 3'd0, 3'(k), 3'd0, 1'b1, 32'd0);
        end
        waitIdle();

        bpMode = 1;
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            logic [XLEN-1:0] imm;
            op = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(0, 15));
            imm = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            applyStimulus(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), imm);
        end
        bpMode = 0;
        waitIdle();

        for (int k = 1; k < NREG; k++) begin
            applyStimulus(OP_OR, 3'd0, 3'(k), 3'd0, 1'b1, 32'd0);
        end
        waitIdle();
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

- Upstream issue stage for the 32-bit registered ALU.
- Accepts one ALU command at a time over a valid/ready handshake and reads operands from a local 8-entry register file (register or immediate B).
- Drives the ALU, waits out its fixed result and zero-flag latency, writes the result back to the register file, and returns a response over a valid/ready handshake.
- Strictly one command in flight, so there are no data hazards.

## Interface
Parameters:
- XLEN, 32, datapath width; must match the ALU
- NREG, 8, register-file entries; register 0 reads as 0
- RW, $clog2(NREG), register index width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept
- cmd_op  in  4  ALU opcode, passed through unmodified
- cmd_rd  in  RW  destination register
- cmd_rs1  in  RW  source A register
- cmd_rs2  in  RW  source B register (ignored if cmd_use_imm)
- cmd_use_imm  in  1  B operand = cmd_imm
- cmd_imm  in  XLEN  immediate B operand
- alu_a  out  XLEN  ALU operand A (registered)
- alu_b  out  XLEN  ALU operand B (registered)
- alu_opcode  out  4  ALU opcode (registered)
- alu_result  in  XLEN  ALU result
- alu_zero  in  1  ALU zero flag
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response
- resp_rd  out  RW  destination written
- resp_data  out  XLEN  result written
- resp_zero  out  1  zero flag for this result
- busy  out  1  state != IDLE

## Operation
FSM states and transitions:
- IDLE → ISSUE on cmd_valid && cmd_ready.
- ISSUE → EXEC → WB, unconditional.
- WB → RESP, unconditional.
- RESP → IDLE on resp_ready.

Command acceptance:
- cmd_ready = (state == IDLE). No command is accepted in any other state, including the RESP cycle where the response handshake completes.
- On the accept edge, latch operands and opcode:
  - alu_a ← RF[cmd_rs1]
  - alu_b ← cmd_use_imm ? cmd_imm : RF[cmd_rs2]
  - alu_opcode ← cmd_op
  - cmd_rd is latched internally
- alu_a, alu_b and alu_opcode hold constant until the next accept.

ALU contract:
- alu_result reflects the inputs one cycle after they are applied.
- alu_zero reflects that result one cycle later still.
- Both are therefore valid for this command in WB.

Writeback (WB edge):
- RF[rd] ← alu_result, skipped when rd == 0.
- resp_data ← alu_result; resp_zero ← alu_zero; resp_rd ← rd.

Response:
- resp_valid = (state == RESP). resp_rd, resp_data and resp_zero stay stable while resp_valid && !resp_ready.

Opcode and register rules:
- Opcodes 7–15 are not trapped. The ALU returns 0, so resp_data = 0 and resp_zero = 1, and the write of 0 to rd still occurs.
- Register 0: reads return 0 regardless of storage; writes are dropped. resp_data still reports the ALU value.

## Timing
- Accept at edge of cycle t. ISSUE in t+1, EXEC in t+2, WB in t+3, resp_valid high from t+4.
- Minimum 5 cycles per command with resp_ready held high.
- Reading rd in the next command returns the new value, because RF is written at the WB edge, before the next accept.
- Reset (rst high at an edge), from any state:
  - FSM → IDLE; the in-flight command is dropped with no RF write and no response.
  - All RF entries → 0.
  - alu_a, alu_b, alu_opcode, resp_rd, resp_data → 0; resp_zero → 1.
  - Resulting outputs: cmd_ready = 1, resp_valid = 0, busy = 0.
  - Reset takes priority over any handshake in the same cycle.
- The ALU shares the same reset source, so its outputs are 0 and zero = 1 after reset.

## Structure
- Shared package alu_pkg:
  - opcode localparams: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_SLL=5, OP_SRL=6
  - XLEN default
  - state enum: IDLE, ISSUE, EXEC, WB, RESP
- One sub-module, alu_seq_regfile:
  - NREG×XLEN storage
  - two combinational read ports and one synchronous write port
  - synchronous clear on rst
  - r0 read forced to 0
- The bench instantiates alu_op_sequencer together with the real ALU.

## Test plan
- Reset, then ADD r1 ← r0 + imm 5 → resp at accept+4, resp_rd = 1, resp_data = 5, resp_zero = 0. Follow with SUB r2 ← r1 − imm 5 → resp_data = 0, resp_zero = 1.
- Dependency chain: r1 = 0xFFFF_FFFF (imm), then ADD r3 ← r1 + r1 → 0xFFFF_FFFE. Then SLL r4 ← r3 << imm 36 → shift amount is 4, result 0xFFFF_FFE0.
- Backpressure: hold resp_ready = 0 for 6 cycles → resp_valid stays high with stable data, cmd_ready stays 0 while cmd_valid = 1, and no second accept occurs until the cycle after the resp handshake.
- Write to r0: XOR r0 ← imm 0xA5 → resp_data = 0xA5. A following OR r5 ← r0 | imm 0 → resp_data = 0, resp_zero = 1.
- Illegal opcode 9 with r1 = 7 → resp_data = 0, resp_zero = 1, RF[rd] = 0.
- Assert rst during EXEC → next cycle: busy = 0, resp_valid = 0, cmd_ready = 1. No response is ever produced for the dropped command, and all registers read 0 afterwards.
